// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcode field values, default boot PC, fetch FSM encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mips_pkg;

    // instr_word[31:26] OP field values seen by the Control decoder
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // First fetch address after reset (MIPS user text segment)
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    // RUN issues and accepts responses; DRAIN discards responses to pre-redirect requests
    typedef enum logic {
        FS_RUN   = 1'b0,
        FS_DRAIN = 1'b1
    } fetchState_t;

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO holding fetched {instruction, pc} entries; flush empties it in one cycle.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: push ignored when full, pop ignored when empty; push and pop together are both honoured.
// Ports: clk, reset (sync, active-high), flush, push/pushData, pop, headData, count, full, empty.
module instr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [CNT_W-1:0] cnt;
    logic             doPush;
    logic             doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full     = (cnt == FULL_CNT);
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
        end else begin
            if (doPush) wrPtr <= nextPtr(wrPtr);
            if (doPop)  rdPtr <= nextPtr(rdPtr);
            case ({doPush, doPop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed through a non-empty head.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch front end: sequential PC requests to imem, in-order responses buffered for decode, redirect/drain.
// Latency: request address to instr_valid is memory latency + 1 cycle.
// Backpressure: requests issued only while in-flight + buffered < DEPTH, so the buffer never overflows.
// Ports: clk, reset; imem_req_valid/ready/addr; imem_rsp_valid/data; instr_valid/ready/word/pc/pc_plus4;
//        redirect_valid/redirect_pc.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int                     ADDR_WIDTH = 32,
    parameter int                     DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(mips_pkg::DEFAULT_RESET_PC),
    parameter int                     DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_word,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [ADDR_WIDTH-1:0] instr_pc_plus4,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(4);
    localparam logic [CNT_W:0]        DEPTH_LIM = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] word;
        logic [ADDR_WIDTH-1:0] pc;
    } bufEntry_t;

    fetchState_t           state, stateNext;
    logic [ADDR_WIDTH-1:0] fetchPc, fetchPcNext;
    logic [ADDR_WIDTH-1:0] rspPc, rspPcNext;     // pc of the next response that will be kept
    logic [CNT_W-1:0]      outstanding, outstandingNext;
    logic [CNT_W-1:0]      dropCnt, dropCntNext;
    logic [CNT_W-1:0]      staleCnt, staleAfter;
    logic [CNT_W:0]        inFlight;
    logic [ADDR_WIDTH-1:0] redirPc;
    logic                  unusedRedirLow;
    logic                  reqValid, reqFire, rspPush, fifoPop;
    bufEntry_t             pushEntry, headEntry;
    logic [CNT_W-1:0]      fifoCount;
    logic                  fifoFull, fifoEmpty;

    assign redirPc        = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unusedRedirLow = ^redirect_pc[1:0];

    // Credit: every accepted request owns a buffer slot until it is popped.
    assign inFlight = {1'b0, outstanding} + {1'b0, fifoCount};
    assign reqValid = !reset && (state == FS_RUN) && !redirect_valid && (inFlight < DEPTH_LIM);
    assign reqFire  = reqValid && imem_req_ready;
    assign rspPush  = imem_rsp_valid && (state == FS_RUN) && !redirect_valid;
    assign fifoPop  = instr_ready && !redirect_valid;

    // Responses still owed by memory for requests that a redirect has made stale;
    // one arriving in the redirect cycle itself is already accounted for.
    assign staleCnt   = (state == FS_RUN) ? outstanding : dropCnt;
    assign staleAfter = staleCnt - CNT_W'(imem_rsp_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FS_RUN;
            fetchPc     <= RESET_PC;
            rspPc       <= RESET_PC;
            outstanding <= '0;
            dropCnt     <= '0;
        end else begin
            state       <= stateNext;
            fetchPc     <= fetchPcNext;
            rspPc       <= rspPcNext;
            outstanding <= outstandingNext;
            dropCnt     <= dropCntNext;
        end
    end

    always_comb begin
        stateNext       = state;
        fetchPcNext     = fetchPc;
        rspPcNext       = rspPc;
        outstandingNext = outstanding;
        dropCntNext     = dropCnt;
        if (redirect_valid) begin
            fetchPcNext     = redirPc;
            rspPcNext       = redirPc;
            outstandingNext = '0;
            dropCntNext     = staleAfter;
            stateNext       = (staleAfter != '0) ? FS_DRAIN : FS_RUN;
        end else begin
            if (reqFire) fetchPcNext = fetchPc + PC_STEP;
            unique case (state)
                FS_RUN: begin
                    if (rspPush) rspPcNext = rspPc + PC_STEP;
                    case ({reqFire, imem_rsp_valid})
                        2'b10:   outstandingNext = outstanding + 1'b1;
                        2'b01:   outstandingNext = outstanding - 1'b1;
                        default: outstandingNext = outstanding;
                    endcase
                end
                FS_DRAIN: begin
                    if (imem_rsp_valid) begin
                        dropCntNext = dropCnt - 1'b1;
                        if (dropCnt == CNT_W'(1)) stateNext = FS_RUN;
                    end
                end
            endcase
        end
    end

    assign pushEntry.word = imem_rsp_data;
    assign pushEntry.pc   = rspPc;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_instr_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (rspPush),
        .pushData (pushEntry),
        .pop      (fifoPop),
        .headData (headEntry),
        .count    (fifoCount),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    assign imem_req_valid = reqValid;
    assign imem_req_addr  = fetchPc;
    assign instr_valid    = !fifoEmpty;
    assign instr_word     = fifoEmpty ? '0 : headEntry.word;
    assign instr_pc       = fifoEmpty ? '0 : headEntry.pc;
    assign instr_pc_plus4 = instr_pc + PC_STEP;

    // Counter range and buffer-overflow guards
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(rspPush && fifoFull));
            assert (!((state == FS_RUN) && imem_rsp_valid && (outstanding == '0)));
            assert (!((state == FS_DRAIN) && imem_rsp_valid && (dropCnt == '0)));
            assert (!(reqFire && (outstanding == CNT_MAX)));
        end
    end

endmodule
